fft_frame_capture: RTL and testbench

Parametrised ping-pong frame buffer between the FFT core output (bin-indexed real/imag stream with valid strobe) and downstream spectral consumers such as pitch detection. It captures complete, index-aligned FFT frames into one of two banks. It exposes a finished bank through a registered random-access read port with a ready/release handshake, and supports continuous and one-shot capture. It replaces ad hoc output capture with a synthesizable, back-pressure-aware block.

---
 rtl/fft_cap_pkg.sv | 21 ++
 rtl/fft_cap_bank_ram.sv | 38 +++
 rtl/fft_frame_capture.sv | 246 ++++++++++++++++++++++++
 tb/tb_fft_frame_capture.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/fft_cap_pkg.sv
// Shared types and defaults for the FFT frame capture buffer.
// Writer FSM states, bank status encoding, default widths.
package fft_cap_pkg;

   localparam int DEF_DATA_W = 18;
   localparam int DEF_ADDR_W = 10;
   localparam int DEF_CNT_W  = 16;

   typedef enum logic [1:0] {
      ST_IDLE     = 2'd0,
      ST_WAIT_SOF = 2'd1,
      ST_CAPTURE  = 2'd2,
      ST_DONE     = 2'd3
   } wr_state_e;

   typedef enum logic {
      BANK_FREE = 1'b0,
      BANK_FULL = 1'b1
   } bank_st_e;

endpackage

// File: rtl/fft_cap_bank_ram.sv
// Two-bank simple dual-port RAM, address {bank, bin}, word {real, imag}.
// Read data is registered and holds when rd_en is low.
module fft_cap_bank_ram
   import fft_cap_pkg::*;
#(
   parameter int DATA_W = DEF_DATA_W,
   parameter int ADDR_W = DEF_ADDR_W
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                wr_en,
   input  logic [ADDR_W:0]     wr_addr,
   input  logic [2*DATA_W-1:0] wr_data,
   input  logic                rd_en,
   input  logic [ADDR_W:0]     rd_addr,
   output logic [2*DATA_W-1:0] rd_data
);

   logic [2*DATA_W-1:0] mem [2**(ADDR_W+1)];
   logic [2*DATA_W-1:0] rd_data_q, rd_data_d;

   always_ff @(posedge clk) begin
      if (wr_en) mem[wr_addr] <= wr_data;
   end

   always_comb begin
      rd_data_d = rd_data_q;
      if (rd_en) rd_data_d = mem[rd_addr];
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) rd_data_q <= '0;
      else        rd_data_q <= rd_data_d;
   end

   assign rd_data = rd_data_q;

endmodule

// File: rtl/fft_frame_capture.sv
// Ping-pong capture of index-aligned FFT frames with a release handshake.
// Optional peak tracker enabled by defining FFT_CAP_PEAK_EN.
module fft_frame_capture
   import fft_cap_pkg::*;
#(
   parameter int DATA_W = DEF_DATA_W,
   parameter int ADDR_W = DEF_ADDR_W,
   parameter int CNT_W  = DEF_CNT_W
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              in_valid,
   input  logic [ADDR_W-1:0] in_addr,
   input  logic [DATA_W-1:0] in_real,
   input  logic [DATA_W-1:0] in_imag,
   input  logic              one_shot,
   input  logic              arm,
   input  logic [ADDR_W-1:0] rd_addr,
   input  logic              rd_en,
   output logic [DATA_W-1:0] rd_real,
   output logic [DATA_W-1:0] rd_imag,
   output logic              frame_ready,
   input  logic              rd_done,
   output logic [CNT_W-1:0]  frame_count,
   output logic              overflow,
   output logic              sync_err
`ifdef FFT_CAP_PEAK_EN
   ,
   output logic [ADDR_W-1:0] peak_bin,
   output logic [DATA_W:0]   peak_mag
`endif
);

   wr_state_e         state_q, state_d;
   bank_st_e          bank_q [2];
   bank_st_e          bank_d [2];
   logic              wr_sel_q, wr_sel_d;
   logic              rd_bank_q, rd_bank_d;
   logic              frame_ready_q, frame_ready_d;
   logic              one_shot_q, one_shot_d;
   logic              overflow_q, overflow_d;
   logic              sync_err_q, sync_err_d;
   logic [ADDR_W-1:0] exp_q, exp_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic              wr_en, complete, release_w, sof;
   logic [2*DATA_W-1:0] rd_data;

   always_comb begin
      state_d       = state_q;
      bank_d        = bank_q;
      wr_sel_d      = wr_sel_q;
      rd_bank_d     = rd_bank_q;
      one_shot_d    = one_shot_q;
      overflow_d    = overflow_q;
      sync_err_d    = sync_err_q;
      exp_d         = exp_q;
      cnt_d         = cnt_q;
      wr_en         = 1'b0;
      complete      = 1'b0;
      release_w     = rd_done && frame_ready_q;
      sof           = in_valid && (in_addr == '0);
      // Release first so a same-cycle completion sees the freed bank
      if (release_w) begin
         bank_d[rd_bank_q] = BANK_FREE;
         rd_bank_d         = ~rd_bank_q;
      end
      unique case (state_q)
         ST_IDLE: begin
            state_d    = ST_WAIT_SOF;
            one_shot_d = one_shot;
         end
         ST_WAIT_SOF: begin
            if (sof) begin
               if (bank_d[wr_sel_q] == BANK_FREE) begin
                  wr_en   = 1'b1;
                  exp_d   = ADDR_W'(1);
                  state_d = ST_CAPTURE;
               end else begin
                  overflow_d = 1'b1;
               end
            end
         end
         ST_CAPTURE: begin
            if (in_valid) begin
               if (in_addr == exp_q) begin
                  wr_en = 1'b1;
                  exp_d = exp_q + ADDR_W'(1);
                  if (in_addr == '1) complete = 1'b1;
               end else begin
                  // Aborted bank was never marked FULL; it is reused
                  sync_err_d = 1'b1;
                  state_d    = ST_WAIT_SOF;
                  one_shot_d = one_shot;
                  if (sof) begin
                     wr_en   = 1'b1;
                     exp_d   = ADDR_W'(1);
                     state_d = ST_CAPTURE;
                  end
               end
            end
         end
         ST_DONE: begin
            if (arm) begin
               state_d    = ST_WAIT_SOF;
               one_shot_d = one_shot;
            end
         end
      endcase
      if (complete) begin
         bank_d[wr_sel_q] = BANK_FULL;
         wr_sel_d         = ~wr_sel_q;
         cnt_d            = cnt_q + CNT_W'(1);
         if (one_shot_q) begin
            state_d = ST_DONE;
         end else begin
            state_d    = ST_WAIT_SOF;
            one_shot_d = one_shot;
         end
      end
      frame_ready_d = !release_w && (bank_d[rd_bank_d] == BANK_FULL);
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q       <= ST_IDLE;
         bank_q[0]     <= BANK_FREE;
         bank_q[1]     <= BANK_FREE;
         wr_sel_q      <= 1'b0;
         rd_bank_q     <= 1'b0;
         frame_ready_q <= 1'b0;
         one_shot_q    <= 1'b0;
         overflow_q    <= 1'b0;
         sync_err_q    <= 1'b0;
         exp_q         <= '0;
         cnt_q         <= '0;
      end else begin
         state_q       <= state_d;
         bank_q        <= bank_d;
         wr_sel_q      <= wr_sel_d;
         rd_bank_q     <= rd_bank_d;
         frame_ready_q <= frame_ready_d;
         one_shot_q    <= one_shot_d;
         overflow_q    <= overflow_d;
         sync_err_q    <= sync_err_d;
         exp_q         <= exp_d;
         cnt_q         <= cnt_d;
      end
   end

   fft_cap_bank_ram #(
      .DATA_W (DATA_W),
      .ADDR_W (ADDR_W)
   ) u_ram (
      .clk     (clk),
      .reset   (reset),
      .wr_en   (wr_en),
      .wr_addr ({wr_sel_q, in_addr}),
      .wr_data ({in_real, in_imag}),
      .rd_en   (rd_en && frame_ready_q),
      .rd_addr ({rd_bank_q, rd_addr}),
      .rd_data (rd_data)
   );

   assign rd_real     = rd_data[2*DATA_W-1:DATA_W];
   assign rd_imag     = rd_data[DATA_W-1:0];
   assign frame_ready = frame_ready_q;
   assign frame_count = cnt_q;
   assign overflow    = overflow_q;
   assign sync_err    = sync_err_q;

`ifdef FFT_CAP_PEAK_EN
   function automatic logic [DATA_W:0] l1_mag(
      input logic [DATA_W-1:0] re,
      input logic [DATA_W-1:0] im
   );
      logic [DATA_W:0] a, b;
      a = {re[DATA_W-1], re};
      b = {im[DATA_W-1], im};
      if (a[DATA_W]) a = -a;
      if (b[DATA_W]) b = -b;
      return a + b;
   endfunction

   logic [ADDR_W-1:0] run_bin_q, run_bin_d;
   logic [DATA_W:0]   run_mag_q, run_mag_d;
   logic [ADDR_W-1:0] bpk_bin_q [2];
   logic [ADDR_W-1:0] bpk_bin_d [2];
   logic [DATA_W:0]   bpk_mag_q [2];
   logic [DATA_W:0]   bpk_mag_d [2];
   logic [ADDR_W-1:0] pk_bin_q, pk_bin_d;
   logic [DATA_W:0]   pk_mag_q, pk_mag_d;
   logic [DATA_W:0]   mag;

   always_comb begin
      run_bin_d = run_bin_q;
      run_mag_d = run_mag_q;
      bpk_bin_d = bpk_bin_q;
      bpk_mag_d = bpk_mag_q;
      pk_bin_d  = pk_bin_q;
      pk_mag_d  = pk_mag_q;
      mag       = l1_mag(in_real, in_imag);
      if (wr_en) begin
         if (in_addr == '0) begin
            run_bin_d = '0;
            run_mag_d = mag;
         end else if (!in_addr[ADDR_W-1] && (mag > run_mag_q)) begin
            run_bin_d = in_addr;
            run_mag_d = mag;
         end
      end
      // Bin N-1 is in the upper half, so run_*_q is already final
      if (complete) begin
         bpk_bin_d[wr_sel_q] = run_bin_q;
         bpk_mag_d[wr_sel_q] = run_mag_q;
      end
      if (!frame_ready_q && frame_ready_d) begin
         pk_bin_d = bpk_bin_d[rd_bank_d];
         pk_mag_d = bpk_mag_d[rd_bank_d];
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         run_bin_q    <= '0;
         run_mag_q    <= '0;
         bpk_bin_q[0] <= '0;
         bpk_bin_q[1] <= '0;
         bpk_mag_q[0] <= '0;
         bpk_mag_q[1] <= '0;
         pk_bin_q     <= '0;
         pk_mag_q     <= '0;
      end else begin
         run_bin_q <= run_bin_d;
         run_mag_q <= run_mag_d;
         bpk_bin_q <= bpk_bin_d;
         bpk_mag_q <= bpk_mag_d;
         pk_bin_q  <= pk_bin_d;
         pk_mag_q  <= pk_mag_d;
      end
   end

   assign peak_bin = pk_bin_q;
   assign peak_mag = pk_mag_q;
`endif

endmodule

// File: tb/tb_fft_frame_capture.sv
// Directed bench for fft_frame_capture with a read-data scoreboard.
// Peak checks are included when FFT_CAP_PEAK_EN is defined.
module tb_fft_frame_capture;

   localparam int DW = 18;
   localparam int AW = 10;
   localparam int CW = 16;
   localparam int N  = 1 << AW;

   typedef struct {
      string         tag;
      logic [DW-1:0] re;
      logic [DW-1:0] im;
   } rd_exp_t;

   logic          clk = 1'b0;
   logic          reset = 1'b0;
   logic          in_valid = 1'b0;
   logic [AW-1:0] in_addr = '0;
   logic [DW-1:0] in_real = '0;
   logic [DW-1:0] in_imag = '0;
   logic          one_shot = 1'b0;
   logic          arm = 1'b0;
   logic [AW-1:0] rd_addr = '0;
   logic          rd_en = 1'b0;
   logic          rd_done = 1'b0;
   logic [DW-1:0] rd_real, rd_imag;
   logic          frame_ready;
   logic [CW-1:0] frame_count;
   logic          overflow, sync_err;
`ifdef FFT_CAP_PEAK_EN
   logic [AW-1:0] peak_bin;
   logic [DW:0]   peak_mag;
`endif

   int      total = 0;
   int      bad = 0;
   rd_exp_t sb[$];

   always #5 clk = ~clk;

   fft_frame_capture #(
      .DATA_W (DW),
      .ADDR_W (AW),
      .CNT_W  (CW)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .in_valid    (in_valid),
      .in_addr     (in_addr),
      .in_real     (in_real),
      .in_imag     (in_imag),
      .one_shot    (one_shot),
      .arm         (arm),
      .rd_addr     (rd_addr),
      .rd_en       (rd_en),
      .rd_real     (rd_real),
      .rd_imag     (rd_imag),
      .frame_ready (frame_ready),
      .rd_done     (rd_done),
      .frame_count (frame_count),
      .overflow    (overflow),
      .sync_err    (sync_err)
`ifdef FFT_CAP_PEAK_EN
      ,
      .peak_bin    (peak_bin),
      .peak_mag    (peak_mag)
`endif
   );

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   function automatic logic [DW-1:0] pat_re(int a, int off, bit spike);
      if (spike) return (a == 37) ? DW'(1000) : '0;
      return DW'(a + off);
   endfunction

   function automatic logic [DW-1:0] pat_im(int a, int off, bit spike);
      if (spike) return '0;
      return DW'(-(a + off));
   endfunction

   task automatic drive_bin(int a, int off, bit spike);
      @(negedge clk);
      in_valid = 1'b1;
      in_addr  = AW'(a);
      in_real  = pat_re(a, off, spike);
      in_imag  = pat_im(a, off, spike);
   endtask

   task automatic send_bins(int first, int last, int off, bit spike);
      for (int a = first; a <= last; a++) drive_bin(a, off, spike);
   endtask

   task automatic idle(int n);
      repeat (n) begin
         @(negedge clk);
         in_valid = 1'b0;
      end
   endtask

   task automatic rd_check(string tag, int a, int off, bit spike);
      rd_exp_t e;
      @(negedge clk);
      in_valid = 1'b0;
      rd_en    = 1'b1;
      rd_addr  = AW'(a);
      e.tag = tag;
      e.re  = pat_re(a, off, spike);
      e.im  = pat_im(a, off, spike);
      sb.push_back(e);
      @(negedge clk);
      rd_en = 1'b0;
      if (sb.size() == 0) begin
         chk({tag, "_sb_empty"}, 32'd0, 32'd1);
      end else begin
         e = sb.pop_front();
         chk({e.tag, "_re"}, 32'(rd_real), 32'(e.re));
         chk({e.tag, "_im"}, 32'(rd_imag), 32'(e.im));
      end
   endtask

   task automatic pulse_done();
      @(negedge clk);
      in_valid = 1'b0;
      rd_done  = 1'b1;
      @(negedge clk);
      rd_done = 1'b0;
   endtask

   initial begin
      // Reset state
      repeat (3) @(negedge clk);
      chk("rst_ready", 32'(frame_ready), 32'd0);
      chk("rst_count", 32'(frame_count), 32'd0);
      chk("rst_ovf", 32'(overflow), 32'd0);
      chk("rst_sync", 32'(sync_err), 32'd0);
      chk("rst_rdre", 32'(rd_real), 32'd0);
      chk("rst_rdim", 32'(rd_imag), 32'd0);
      reset = 1'b1;
      idle(2);

      // Ramp frame, frame_ready one cycle after bin N-1
      send_bins(0, N - 2, 0, 0);
      drive_bin(N - 1, 0, 0);
      chk("ramp_ready_pre", 32'(frame_ready), 32'd0);
      idle(1);
      chk("ramp_ready", 32'(frame_ready), 32'd1);
      chk("ramp_count", 32'(frame_count), 32'd1);
      rd_check("ramp_rd5", 5, 0, 0);
      rd_check("ramp_rd1023", N - 1, 0, 0);
      rd_check("ramp_rd0", 0, 0, 0);
      pulse_done();
      chk("ramp_rel_low", 32'(frame_ready), 32'd0);
      idle(1);
      chk("ramp_rel_low2", 32'(frame_ready), 32'd0);

      // Stream joined mid-frame at bin 17
      send_bins(17, N - 1, 100, 0);
      idle(1);
      chk("mid_count0", 32'(frame_count), 32'd1);
      chk("mid_ready0", 32'(frame_ready), 32'd0);
      send_bins(0, N - 1, 200, 0);
      idle(1);
      chk("mid_count", 32'(frame_count), 32'd2);
      chk("mid_sync", 32'(sync_err), 32'd0);
      rd_check("mid_rd17", 17, 200, 0);
      pulse_done();

      // Bin 100 followed by 102
      send_bins(0, 100, 300, 0);
      drive_bin(102, 300, 0);
      send_bins(103, N - 1, 300, 0);
      idle(1);
      chk("skip_sync", 32'(sync_err), 32'd1);
      chk("skip_count", 32'(frame_count), 32'd2);
      chk("skip_ready", 32'(frame_ready), 32'd0);
      send_bins(0, N - 1, 400, 0);
      idle(1);
      chk("skip_next_count", 32'(frame_count), 32'd3);
      rd_check("skip_rd100", 100, 400, 0);
      pulse_done();

      // Three back-to-back frames, no release
      chk("ovf_pre", 32'(overflow), 32'd0);
      send_bins(0, N - 1, 500, 0);
      send_bins(0, N - 1, 600, 0);
      send_bins(0, N - 1, 700, 0);
      idle(1);
      chk("ovf_set", 32'(overflow), 32'd1);
      chk("ovf_count", 32'(frame_count), 32'd5);
      chk("ovf_ready", 32'(frame_ready), 32'd1);
      rd_check("ovf_rd_f1", 3, 500, 0);
      pulse_done();
      chk("ovf_gap", 32'(frame_ready), 32'd0);
      idle(1);
      chk("ovf_f2_ready", 32'(frame_ready), 32'd1);
      rd_check("ovf_rd_f2", 3, 600, 0);
      pulse_done();
      chk("ovf_gap2", 32'(frame_ready), 32'd0);
      idle(1);
      chk("ovf_f3_dropped", 32'(frame_ready), 32'd0);

      // Reset mid-capture with a held frame
      send_bins(0, N - 1, 800, 0);
      idle(1);
      chk("pre_rst_count", 32'(frame_count), 32'd6);
      rd_check("pre_rst_rd2", 2, 800, 0);
      one_shot = 1'b1;
      send_bins(0, 499, 900, 0);
      drive_bin(500, 900, 0);
      reset = 1'b0;
      #1;
      chk("mrst_ready", 32'(frame_ready), 32'd0);
      chk("mrst_count", 32'(frame_count), 32'd0);
      chk("mrst_ovf", 32'(overflow), 32'd0);
      chk("mrst_sync", 32'(sync_err), 32'd0);
      chk("mrst_rdre", 32'(rd_real), 32'd0);
      chk("mrst_rdim", 32'(rd_imag), 32'd0);
`ifdef FFT_CAP_PEAK_EN
      chk("mrst_pkbin", 32'(peak_bin), 32'd0);
      chk("mrst_pkmag", 32'(peak_mag), 32'd0);
`endif
      idle(3);
      reset = 1'b1;
      idle(2);

      // One-shot spike frame after reset
      send_bins(0, N - 1, 0, 1);
      idle(1);
      chk("os_ready", 32'(frame_ready), 32'd1);
      chk("os_count", 32'(frame_count), 32'd1);
      chk("os_sync", 32'(sync_err), 32'd0);
`ifdef FFT_CAP_PEAK_EN
      chk("os_pkbin", 32'(peak_bin), 32'd37);
      chk("os_pkmag", 32'(peak_mag), 32'd1000);
`endif
      rd_check("os_rd37", 37, 0, 1);
      rd_check("os_rd5", 5, 0, 1);
      send_bins(0, N - 1, 0, 0);
      idle(1);
      chk("os_ign_count", 32'(frame_count), 32'd1);
      chk("os_ign_ovf", 32'(overflow), 32'd0);
      rd_check("os_ign_rd37", 37, 0, 1);
      pulse_done();
      idle(1);
      chk("os_rel_ready", 32'(frame_ready), 32'd0);

      // Arm re-enables capture
      one_shot = 1'b0;
      @(negedge clk);
      arm = 1'b1;
      @(negedge clk);
      arm = 1'b0;
      send_bins(0, N - 1, 0, 0);
      idle(1);
      chk("arm_count", 32'(frame_count), 32'd2);
      chk("arm_ready", 32'(frame_ready), 32'd1);
`ifdef FFT_CAP_PEAK_EN
      chk("arm_pkbin", 32'(peak_bin), 32'd511);
      chk("arm_pkmag", 32'(peak_mag), 32'd1022);
`endif
      rd_check("arm_rd9", 9, 0, 0);
      chk("sb_drained", 32'(sb.size()), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
